b_bop_fu: RTL and testbench

Pipelined functional-unit wrapper around the combinational ternary bitwise `bop` datapath. It accepts `bop` requests (three 32-bit operands, 8-bit truth table and a tag) from the issue stage over a valid/ready channel. It registers the operands, evaluates the LUT per bit and returns tagged results to writeback over a second valid/ready channel. It also provides full backpressure, a flush input, and a completed-operation counter.

---
 rtl/b_bop_fu_pkg.sv | 13 +
 rtl/b_bop_fu_if.sv | 29 ++
 rtl/b_bop.sv | 20 ++
 rtl/b_bop_fu.sv | 98 +++++++++
 tb/tb_b_bop_fu.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/b_bop_fu_pkg.sv
// Shared types and truth-table constants for the bop functional unit.
package b_bop_fu_pkg;

   localparam int unsigned XLEN = 32;

   typedef logic [XLEN-1:0] word_t;

   localparam logic [7:0] BOP_XOR3 = 8'h96;
   localparam logic [7:0] BOP_MAJ  = 8'hE8;
   localparam logic [7:0] BOP_RS1  = 8'hAA;
   localparam logic [7:0] BOP_ZERO = 8'h00;

endpackage

// File: rtl/b_bop_fu_if.sv
// Issue-side request channel and writeback-side response channel of the bop unit.
interface b_bop_fu_if
   import b_bop_fu_pkg::*;
#(
   parameter int TAG_W = 4
);
   logic             req_valid;
   logic             req_ready;
   word_t            req_rs1;
   word_t            req_rs2;
   word_t            req_rd;
   logic [7:0]       req_lut;
   logic [TAG_W-1:0] req_tag;

   logic             rsp_valid;
   logic             rsp_ready;
   word_t            rsp_result;
   logic [TAG_W-1:0] rsp_tag;

   modport master (
      output req_valid, req_rs1, req_rs2, req_rd, req_lut, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_tag
   );

   modport slave (
      input  req_valid, req_rs1, req_rs2, req_rd, req_lut, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_tag
   );
endinterface

// File: rtl/b_bop.sv
// Combinational ternary bitwise operation: each result bit is looked up in an
// 8-entry truth table indexed by {rd, rs2, rs1} at that bit position.
module b_bop
   import b_bop_fu_pkg::*;
(
   input  word_t      rs1,
   input  word_t      rs2,
   input  word_t      rd,
   input  logic [7:0] lut,
   output word_t      result
);

   always_comb begin
      result = '0;
      for (int i = 0; i < XLEN; i++) begin
         result[i] = lut[{rd[i], rs2[i], rs1[i]}];
      end
   end

endmodule

// File: rtl/b_bop_fu.sv
// Two-stage pipelined wrapper around b_bop with valid/ready on both sides,
// synchronous flush and a wrapping count of completed responses.
module b_bop_fu
   import b_bop_fu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        flush,
   b_bop_fu_if.slave   bus,
   output logic        busy,
   output logic [31:0] op_count
);

   logic             r_s1_valid;
   word_t            r_s1_rs1;
   word_t            r_s1_rs2;
   word_t            r_s1_rd;
   logic [7:0]       r_s1_lut;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   word_t            r_s2_result;
   logic [TAG_W-1:0] r_s2_tag;

   logic [31:0]      r_op_count;

   logic             w_s2_adv;
   logic             w_req_ready;
   logic             w_accept;
   logic             w_rsp_hs;
   word_t            w_result;

   assign w_s2_adv    = !r_s2_valid || bus.rsp_ready;
   assign w_req_ready = (!r_s1_valid || w_s2_adv) && !flush;
   assign w_accept    = bus.req_valid && w_req_ready;
   assign w_rsp_hs    = r_s2_valid && bus.rsp_ready;

   b_bop u_bop (
      .rs1    (r_s1_rs1),
      .rs2    (r_s1_rs2),
      .rd     (r_s1_rd),
      .lut    (r_s1_lut),
      .result (w_result)
   );

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (flush) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
         end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
         end
         if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
         end
      end
   end

   // Payload registers carry no reset; they are only meaningful under their valid bit.
   always_ff @(posedge g_clk) begin
      if (w_accept) begin
         r_s1_rs1 <= bus.req_rs1;
         r_s1_rs2 <= bus.req_rs2;
         r_s1_rd  <= bus.req_rd;
         r_s1_lut <= bus.req_lut;
         r_s1_tag <= bus.req_tag;
      end
      if (w_s2_adv) begin
         r_s2_result <= w_result;
         r_s2_tag    <= r_s1_tag;
      end
   end

   // Counts handshakes even in a flush cycle; flush does not clear it.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_op_count <= '0;
      end else if (w_rsp_hs) begin
         r_op_count <= r_op_count + 32'd1;
      end
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.rsp_valid  = r_s2_valid;
   assign bus.rsp_result = r_s2_result;
   assign bus.rsp_tag    = r_s2_tag;
   assign busy           = r_s1_valid || r_s2_valid;
   assign op_count       = r_op_count;

endmodule

// File: tb/tb_b_bop_fu.sv
// Self-checking bench for b_bop_fu: queue-based reference model of in-flight ops.
module tb_b_bop_fu;
   import b_bop_fu_pkg::*;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        flush;
   logic        busy;
   logic [31:0] op_count;

   b_bop_fu_if #(.TAG_W(4)) bus ();

   b_bop_fu #(.TAG_W(4)) dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .flush    (flush),
      .bus      (bus),
      .busy     (busy),
      .op_count (op_count)
   );

   always #5 g_clk = ~g_clk;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  tag;
      int          age;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_count;
   int          pass_cnt = 0;
   int          total_cnt = 0;

   logic        d_valid, d_rr, d_fl;
   logic [31:0] d_rs1, d_rs2, d_rd;
   logic [7:0]  d_lut;
   logic [3:0]  d_tag;

   logic        e_ready, e_valid, e_busy;
   logic [31:0] e_res;
   logic [3:0]  e_tag;

   function automatic logic [31:0] ref_bop(input logic [31:0] a, b, c, input logic [7:0] l);
      logic [31:0] r;
      int idx;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         idx  = 4 * int'(c[i]) + 2 * int'(b[i]) + int'(a[i]);
         r[i] = l[idx];
      end
      return r;
   endfunction

   // Apply inputs just after the falling edge and derive expected outputs from the model.
   task automatic drive(input logic v, input logic [31:0] a, b, c, input logic [7:0] l,
                        input logic [3:0] t, input logic rr, input logic fl);
      d_valid = v; d_rs1 = a; d_rs2 = b; d_rd = c; d_lut = l; d_tag = t; d_rr = rr; d_fl = fl;
      bus.req_valid = v; bus.req_rs1 = a; bus.req_rs2 = b; bus.req_rd = c;
      bus.req_lut = l; bus.req_tag = t; bus.rsp_ready = rr; flush = fl;
      #1;
      e_ready = !fl && (q.size() < 2 || rr);
      e_valid = (q.size() > 0) && (q[0].age >= 1);
      e_res   = e_valid ? q[0].res : 32'h0;
      e_tag   = e_valid ? q[0].tag : 4'h0;
      e_busy  = q.size() > 0;
   endtask

   task automatic drive_idle(input logic rr);
      drive(1'b0, 32'h0, 32'h0, 32'h0, 8'h00, 4'h0, rr, 1'b0);
   endtask

   task automatic tick();
      logic hs, acc;
      hs  = e_valid && d_rr;
      acc = d_valid && e_ready;
      @(posedge g_clk);
      if (hs) begin
         void'(q.pop_front());
         m_count = m_count + 32'd1;
      end
      foreach (q[i]) q[i].age++;
      if (d_fl) q.delete();
      else if (acc) q.push_back('{ref_bop(d_rs1, d_rs2, d_rd, d_lut), d_tag, 0});
      @(negedge g_clk);
   endtask

   task automatic test_reset();
      g_resetn = 1'b0;
      drive_idle(1'b1);
      q.delete();
      m_count = '0;
      total_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 32'h0 || bus.req_ready !== 1'b1)
         $display("FAIL reset: rsp_valid=%b busy=%b op_count=%h req_ready=%b, want 0 0 0 1",
                  bus.rsp_valid, busy, op_count, bus.req_ready);
      else pass_cnt++;
      @(negedge g_clk);
      g_resetn = 1'b1;
   endtask

   task automatic test_luts();
      logic [7:0]  luts[4];
      logic [31:0] want[4];
      logic [3:0]  tags[4];
      luts = '{BOP_XOR3, BOP_MAJ, BOP_RS1, BOP_ZERO};
      want = '{32'h96969696, 32'hE8E8E8E8, 32'hF0F0F0F0, 32'h00000000};
      tags = '{4'd3, 4'd5, 4'd9, 4'd12};
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA, luts[k], tags[k], 1'b1, 1'b0);
         total_cnt++;
         if (bus.req_ready !== 1'b1) $display("FAIL lut_accept[%0d]: req_ready=%b want 1", k, bus.req_ready);
         else pass_cnt++;
         tick();
         drive_idle(1'b1);
         total_cnt++;
         if (bus.rsp_valid !== 1'b0) $display("FAIL lut_early[%0d]: rsp_valid=%b want 0", k, bus.rsp_valid);
         else pass_cnt++;
         tick();
         drive_idle(1'b1);
         total_cnt++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== want[k] || bus.rsp_tag !== tags[k] ||
             e_res !== want[k])
            $display("FAIL lut_result[%0d]: valid=%b result=%h tag=%0d, want 1 %h %0d",
                     k, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, want[k], tags[k]);
         else pass_cnt++;
         tick();
         drive_idle(1'b1);
         total_cnt++;
         if (op_count !== 32'(k + 1) || busy !== 1'b0)
            $display("FAIL lut_count[%0d]: op_count=%0d busy=%b, want %0d 0", k, op_count, busy, k + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 11; k++) begin
         drive(k < 8, $urandom(), $urandom(), $urandom(), 8'($urandom_range(255)), 4'(k), 1'b1, 1'b0);
         total_cnt++;
         if (bus.req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: req_ready=%b want 1", k, bus.req_ready);
         else pass_cnt++;
         total_cnt++;
         if ((k >= 2 && k < 10) != (bus.rsp_valid === 1'b1) || bus.rsp_valid !== e_valid ||
             (e_valid && (bus.rsp_result !== e_res || bus.rsp_tag !== 4'(k - 2))))
            $display("FAIL b2b_rsp[%0d]: valid=%b result=%h tag=%0d, want valid=%b result=%h tag=%0d",
                     k, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, e_valid, e_res, k - 2);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 16; k++) begin
         drive(k < 10, $urandom(), $urandom(), $urandom(), 8'($urandom_range(255)),
               4'(k), !(k >= 3 && k < 8), 1'b0);
         total_cnt++;
         if (bus.req_ready !== e_ready || (k >= 4 && k < 8 && bus.req_ready !== 1'b0))
            $display("FAIL bp_ready[%0d]: req_ready=%b want %b", k, bus.req_ready, e_ready);
         else pass_cnt++;
         total_cnt++;
         if (bus.rsp_valid !== e_valid || (e_valid && (bus.rsp_result !== e_res || bus.rsp_tag !== e_tag)))
            $display("FAIL bp_rsp[%0d]: valid=%b result=%h tag=%0d, want %b %h %0d",
                     k, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, e_valid, e_res, e_tag);
         else pass_cnt++;
         total_cnt++;
         if (busy !== e_busy || op_count !== m_count)
            $display("FAIL bp_state[%0d]: busy=%b op_count=%0d, want %b %0d", k, busy, op_count, e_busy, m_count);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_flush();
      logic [31:0] cnt0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, $urandom(), $urandom(), $urandom(), BOP_XOR3, 4'(k + 1), 1'b0, 1'b0);
         tick();
      end
      cnt0 = op_count;
      drive(1'b1, $urandom(), $urandom(), $urandom(), BOP_MAJ, 4'd7, 1'b0, 1'b1);
      total_cnt++;
      if (bus.req_ready !== 1'b0 || busy !== 1'b1 || bus.rsp_valid !== 1'b1)
         $display("FAIL flush_pre: req_ready=%b busy=%b rsp_valid=%b, want 0 1 1", bus.req_ready, busy, bus.rsp_valid);
      else pass_cnt++;
      tick();
      drive_idle(1'b1);
      total_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== cnt0 || e_busy !== 1'b0)
         $display("FAIL flush_post: rsp_valid=%b busy=%b op_count=%0d, want 0 0 %0d", bus.rsp_valid, busy, op_count, cnt0);
      else pass_cnt++;
      drive(1'b1, 32'hF0F0F0F0, 32'hCCCCCCCC, 32'hAAAAAAAA, BOP_RS1, 4'd11, 1'b1, 1'b0);
      tick();
      drive_idle(1'b1);
      tick();
      drive_idle(1'b1);
      total_cnt++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'hF0F0F0F0 || bus.rsp_tag !== 4'd11)
         $display("FAIL flush_next: valid=%b result=%h tag=%0d, want 1 f0f0f0f0 11", bus.rsp_valid, bus.rsp_result, bus.rsp_tag);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_random();
      for (int k = 0; k < 300; k++) begin
         drive($urandom_range(99) < 70, $urandom(), $urandom(), $urandom(), 8'($urandom_range(255)),
               4'($urandom_range(15)), $urandom_range(99) < 60, $urandom_range(99) < 3);
         total_cnt++;
         if (bus.req_ready !== e_ready) $display("FAIL rnd_ready[%0d]: req_ready=%b want %b", k, bus.req_ready, e_ready);
         else pass_cnt++;
         total_cnt++;
         if (bus.rsp_valid !== e_valid || (e_valid && (bus.rsp_result !== e_res || bus.rsp_tag !== e_tag)))
            $display("FAIL rnd_rsp[%0d]: valid=%b result=%h tag=%0d, want %b %h %0d",
                     k, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, e_valid, e_res, e_tag);
         else pass_cnt++;
         total_cnt++;
         if (busy !== e_busy || op_count !== m_count)
            $display("FAIL rnd_state[%0d]: busy=%b op_count=%0d, want %b %0d", k, busy, op_count, e_busy, m_count);
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_wrap();
      drive_idle(1'b1);
      for (int k = 0; k < 3; k++) tick();
      force dut.r_op_count = 32'hFFFFFFFF;
      #1;
      release dut.r_op_count;
      m_count = 32'hFFFFFFFF;
      drive(1'b1, $urandom(), $urandom(), $urandom(), BOP_XOR3, 4'd2, 1'b1, 1'b0);
      tick();
      drive_idle(1'b1);
      total_cnt++;
      if (op_count !== 32'hFFFFFFFF) $display("FAIL wrap_pre: op_count=%h want ffffffff", op_count);
      else pass_cnt++;
      tick();
      drive_idle(1'b1);
      tick();
      drive_idle(1'b1);
      total_cnt++;
      if (op_count !== 32'h0 || m_count !== 32'h0) $display("FAIL wrap: op_count=%h want 00000000", op_count);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, $urandom(), $urandom(), $urandom(), BOP_MAJ, 4'(k), k == 2, 1'b0);
         tick();
      end
      drive(1'b1, $urandom(), $urandom(), $urandom(), BOP_MAJ, 4'd6, 1'b0, 1'b0);
      total_cnt++;
      if (busy !== 1'b1 || op_count === 32'h0)
         $display("FAIL arst_pre: busy=%b op_count=%0d, want 1 nonzero", busy, op_count);
      else pass_cnt++;
      #2;
      g_resetn = 1'b0;
      #1;
      total_cnt++;
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0 || op_count !== 32'h0 || bus.req_ready !== 1'b1)
         $display("FAIL arst: rsp_valid=%b busy=%b op_count=%h req_ready=%b, want 0 0 0 1",
                  bus.rsp_valid, busy, op_count, bus.req_ready);
      else pass_cnt++;
      q.delete();
      m_count = '0;
      @(negedge g_clk);
      g_resetn = 1'b1;
      drive_idle(1'b1);
      tick();
   endtask

   initial begin
      test_reset();
      test_luts();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_random();
      test_wrap();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
